key_event_queue: RTL and testbench

Input-side event stage: consumes the debounced, synchronised push-button levels (active-low, one per key) and turns each press into a queued event carrying the key index and an 8-bit switch snapshot. The processor core drains the events through a valid/ready handshake. A small FIFO decouples human-speed presses from the core's fetch/execute cadence. An optional auto-repeat generates events while a key is held.

---
 rtl/key_event_queue_if.sv | 34 +++
 rtl/key_event_queue.sv | 156 +++++++++++++++
 tb/tb_key_event_queue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/key_event_queue_if.sv
// -----------------------------------------------------------------------------
// key_event_queue_if
// Valid/ready event channel between the key event queue and the processor core.
//
// Signals:
//   evt_valid  queue has an event at its head
//   evt_ready  consumer accepts the head event on this rising edge
//   evt_key    key index (0..3) of the head event
//   evt_data   8-bit switch snapshot taken when the event was queued
//
// Modports:
//   master  event producer (the queue)
//   slave   event consumer (the core)
// -----------------------------------------------------------------------------
interface key_event_queue_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_key;
  logic [7:0] evt_data;

  modport master (
    output evt_valid,
    output evt_key,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_key,
    input  evt_data,
    output evt_ready
  );
endinterface

// File: rtl/key_event_queue.sv
// -----------------------------------------------------------------------------
// key_event_queue
// Turns push-button presses (active-low, debounced, synchronised) into queued
// events {key index, switch snapshot}. A small show-ahead FIFO decouples
// human-speed presses from the consumer, which drains it over valid/ready.
//
// Optional feature macro: KEY_REPEAT_EN
//   defined   : a held key issues repeat events, first after HOLD_CYCLES,
//               then every REPEAT_CYCLES
//   undefined : exactly one event per press, no repeat counters built
//
// Parameters:
//   DEPTH          FIFO entries (power of two, >= 2)
//   HOLD_CYCLES    hold time before the first repeat
//   REPEAT_CYCLES  period of later repeats
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   keys      key levels, 0 = pressed
//   sw        switch data, snapshotted at FIFO write time
//   evt       event channel (master side): evt_valid/evt_key/evt_data out,
//             evt_ready in; key/data read 0 while the queue is empty
//   count     number of occupied entries
//   overflow  sticky: an event was merged into a still-pending one (lost)
// -----------------------------------------------------------------------------
module key_event_queue #(
  parameter int DEPTH         = 4,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             keys,
  input  logic [7:0]             sw,
  key_event_queue_if.master      evt,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  // Parameter sanity: repeat reload value HOLD-REPEAT must be non-negative.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (REPEAT_CYCLES < 1) || (REPEAT_CYCLES > HOLD_CYCLES)) begin : g_bad_cfg
    $error("key_event_queue: illegal DEPTH/HOLD_CYCLES/REPEAT_CYCLES");
  end

  logic [3:0]    prev;
  logic [3:0]    pending;
  logic [3:0]    press;
  logic [3:0]    tick;
  logic [3:0]    evt_in;
  logic [3:0]    clr;
  logic [1:0]    sel;
  logic          has_pend;
  logic          push;
  logic          pop;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [1:0]    mem_key  [DEPTH];
  logic [7:0]    mem_data [DEPTH];

  assign press  = prev & ~keys;
  assign evt_in = press | tick;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(HOLD_CYCLES);
  localparam logic [RW-1:0] LAST_C   = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RELOAD_C = RW'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [RW-1:0] rpt_cnt [4];

  always_comb begin
    tick = '0;
    for (int i = 0; i < 4; i++) begin
      tick[i] = ~keys[i] & ~press[i] & (rpt_cnt[i] == LAST_C);
    end
  end

  // Reloading to HOLD-REPEAT after a tick makes later repeats REPEAT apart.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset || keys[i] || press[i]) begin
        rpt_cnt[i] <= '0;
      end else if (tick[i]) begin
        rpt_cnt[i] <= RELOAD_C;
      end else begin
        rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
      end
    end
  end
`else
  assign tick = '0;
`endif

  // Fixed-priority arbiter: lowest-index pending key wins.
  always_comb begin
    sel      = '0;
    has_pend = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        sel      = 2'(i);
        has_pend = 1'b1;
      end
    end
  end

  assign pop  = evt.evt_valid & evt.evt_ready;
  // A full FIFO still accepts a push when the head is leaving this cycle.
  assign push = has_pend & ((count != FULL_C) | pop);

  always_comb begin
    clr = '0;
    if (push) clr[sel] = 1'b1;
  end

  // ---- control state: edge detect, pending set, pointers, occupancy ----
  always_ff @(posedge clk) begin
    prev <= keys;
    if (reset) begin
      pending  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | evt_in;
      // A bit being written this cycle is free again, so re-setting it loses nothing.
      if (|(evt_in & pending & ~clr)) overflow <= 1'b1;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- event storage (data only, not reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem_key[tail]  <= sel;
      mem_data[tail] <= sw;
    end
  end

  // ---- show-ahead head outputs ----
  assign evt.evt_valid = (count != '0);
  assign evt.evt_key   = evt.evt_valid ? mem_key[head]  : 2'd0;
  assign evt.evt_data  = evt.evt_valid ? mem_data[head] : 8'd0;

endmodule

// File: tb/tb_key_event_queue.sv
// -----------------------------------------------------------------------------
// tb_key_event_queue
// Directed bench for key_event_queue (DEPTH=4, HOLD_CYCLES=20, REPEAT_CYCLES=8).
// A per-cycle vector table covers single press, simultaneous press, full FIFO
// and overflow; hand-written sequences cover reset and auto-repeat.
// -----------------------------------------------------------------------------
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys;
  logic [7:0] sw;
  logic [2:0] count;
  logic       overflow;

  key_event_queue_if bus();

  key_event_queue #(
    .DEPTH        (4),
    .HOLD_CYCLES  (20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .keys    (keys),
    .sw      (sw),
    .evt     (bus),
    .count   (count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] keys;
    logic [7:0] sw;
    logic       rdy;
    logic       e_valid;
    logic [1:0] e_key;
    logic [7:0] e_data;
    logic [2:0] e_count;
    logic       e_ovf;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [3:0] k, input logic [7:0] s, input logic r);
    keys          = k;
    sw            = s;
    bus.evt_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic [1:0] k,
                          input logic [7:0] d, input logic [2:0] c, input logic o);
    chk({tag, ".valid"}, 32'(bus.evt_valid), 32'(v));
    chk({tag, ".key"},   32'(bus.evt_key),   32'(k));
    chk({tag, ".data"},  32'(bus.evt_data),  32'(d));
    chk({tag, ".count"}, 32'(count),         32'(c));
    chk({tag, ".ovf"},   32'(overflow),      32'(o));
  endtask

  initial begin
    int n_evt;
    int exp_n;
    int exp_t [4];
    int got_t [4];

    //            keys   sw     rdy   valid key   data   cnt   ovf
    // single press of key2
    vecs[0]  = '{4'hF, 8'hA5, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b0};
    vecs[1]  = '{4'hB, 8'hA5, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b0};
    vecs[2]  = '{4'hB, 8'hA5, 1'b0, 1'b1, 2'd2, 8'hA5, 3'd1, 1'b0};
    vecs[3]  = '{4'hF, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 3'd0, 1'b0};
    vecs[4]  = '{4'hF, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b0};
    // all four keys at once, sw 1..4 on the write cycles
    vecs[5]  = '{4'h0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b0};
    vecs[6]  = '{4'h0, 8'h01, 1'b0, 1'b1, 2'd0, 8'h01, 3'd1, 1'b0};
    vecs[7]  = '{4'h0, 8'h02, 1'b0, 1'b1, 2'd0, 8'h01, 3'd2, 1'b0};
    vecs[8]  = '{4'h0, 8'h03, 1'b0, 1'b1, 2'd0, 8'h01, 3'd3, 1'b0};
    vecs[9]  = '{4'h0, 8'h04, 1'b0, 1'b1, 2'd0, 8'h01, 3'd4, 1'b0};
    // full FIFO: re-press key1, it waits; one pop lets it in the same cycle
    vecs[10] = '{4'h2, 8'h55, 1'b0, 1'b1, 2'd0, 8'h01, 3'd4, 1'b0};
    vecs[11] = '{4'h0, 8'h55, 1'b0, 1'b1, 2'd0, 8'h01, 3'd4, 1'b0};
    vecs[12] = '{4'h0, 8'h66, 1'b0, 1'b1, 2'd0, 8'h01, 3'd4, 1'b0};
    vecs[13] = '{4'h0, 8'h77, 1'b1, 1'b1, 2'd1, 8'h02, 3'd4, 1'b0};
    // overflow: key1 pressed twice while its pending bit is held
    vecs[14] = '{4'h2, 8'h00, 1'b0, 1'b1, 2'd1, 8'h02, 3'd4, 1'b0};
    vecs[15] = '{4'h0, 8'h00, 1'b0, 1'b1, 2'd1, 8'h02, 3'd4, 1'b0};
    vecs[16] = '{4'h2, 8'h00, 1'b0, 1'b1, 2'd1, 8'h02, 3'd4, 1'b0};
    vecs[17] = '{4'h0, 8'h00, 1'b0, 1'b1, 2'd1, 8'h02, 3'd4, 1'b1};
    vecs[18] = '{4'h0, 8'h88, 1'b1, 1'b1, 2'd2, 8'h03, 3'd4, 1'b1};
    // drain: exactly one key1 event (0x88) from the merged pair
    vecs[19] = '{4'h0, 8'h00, 1'b1, 1'b1, 2'd3, 8'h04, 3'd3, 1'b1};
    vecs[20] = '{4'h0, 8'h00, 1'b1, 1'b1, 2'd1, 8'h77, 3'd2, 1'b1};
    vecs[21] = '{4'h0, 8'h00, 1'b1, 1'b1, 2'd1, 8'h88, 3'd1, 1'b1};
    vecs[22] = '{4'hF, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 3'd0, 1'b1};
    vecs[23] = '{4'hF, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 3'd0, 1'b1};

    // reset state
    reset = 1'b1;
    step(4'hF, 8'h00, 1'b0);
    step(4'hF, 8'h00, 1'b0);
    chk_outs("reset", 1'b0, 2'd0, 8'h00, 3'd0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].keys, vecs[i].sw, vecs[i].rdy);
      chk_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_key,
               vecs[i].e_data, vecs[i].e_count, vecs[i].e_ovf);
    end

    // reset mid-operation: 3 queued, key0 held, pop requested on the reset edge
    step(4'h8, 8'h10, 1'b0);
    step(4'h8, 8'h11, 1'b0);
    step(4'h8, 8'h12, 1'b0);
    step(4'h8, 8'h13, 1'b0);
    chk("rst_pre.count", 32'(count), 32'd3);
    reset = 1'b1;
    step(4'h8, 8'h14, 1'b1);
    reset = 1'b0;
    chk_outs("rst_edge", 1'b0, 2'd0, 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(4'h8, 8'h00, 1'b0);
    chk("rst_held.count", 32'(count), 32'd0);
    chk("rst_held.valid", 32'(bus.evt_valid), 32'd0);
    step(4'hF, 8'h00, 1'b0);
    chk("rst_release.count", 32'(count), 32'd0);
    step(4'hE, 8'h3C, 1'b0);
    chk("repress.k.count", 32'(count), 32'd0);
    step(4'hE, 8'h3C, 1'b0);
    chk_outs("repress", 1'b1, 2'd0, 8'h3C, 3'd1, 1'b0);
    step(4'hF, 8'h00, 1'b1);
    chk("repress_pop.count", 32'(count), 32'd0);

    // auto-repeat: key3 held for 44 edges, consumer always ready
`ifdef KEY_REPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    exp_t = '{1, 21, 29, 37};
    got_t = '{-1, -1, -1, -1};
    n_evt = 0;
    step(4'hF, 8'h00, 1'b1);
    for (int j = 0; j < 50; j++) begin
      step((j < 44) ? 4'h7 : 4'hF, 8'(j), 1'b1);
      if (bus.evt_valid) begin
        chk($sformatf("rpt%0d.key", n_evt), 32'(bus.evt_key), 32'd3);
        chk($sformatf("rpt%0d.data", n_evt), 32'(bus.evt_data), 32'(j));
        if (n_evt < 4) got_t[n_evt] = j;
        n_evt++;
      end
    end
    chk("rpt.events", 32'(n_evt), 32'(exp_n));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rpt.time%0d", i), 32'(got_t[i]), (i < exp_n) ? 32'(exp_t[i]) : 32'hFFFF_FFFF);
    end
    chk("rpt.ovf", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
